frame_stack_feeder: RTL

//  Producer side of the multi-frame pixel bus consumed by the x/y/t derivative calculators.

---
 rtl/optflow_pkg.sv | 26 ++
 rtl/frame_slot_ram.sv | 25 ++
 rtl/frame_stack_feeder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/optflow_pkg.sv
// optflow_pkg: shared pixel-bus defaults and types for the
// optical-flow front end (frame stack feeder, derivative stage).
package optflow_pkg;

   localparam int PIXEL_WIDTH           = 8;
   localparam int FRAME_WIDTH           = 1024;
   localparam int FRAME_HEIGHT          = 768;
   localparam int NUM_DERIVATIVE_FRAMES = 3;

   localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

   // Index width that stays >= 1 bit for degenerate sizes.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;
   typedef logic [$clog2(FRAME_PIXELS)-1:0] frame_addr_t;
   typedef logic [idx_w(NUM_DERIVATIVE_FRAMES-1)-1:0] slot_idx_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } feed_state_t;

endpackage

// File: rtl/frame_slot_ram.sv
// frame_slot_ram: one history frame slot, simple dual-port,
// registered read that returns the pre-write word on collision.
module frame_slot_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/frame_stack_feeder.sv
// frame_stack_feeder: packs the live pixel with co-located history pixels.
// Optional FRAME_STACK_ERR_CNT_EN adds a saturating short-frame counter.
module frame_stack_feeder #(
   parameter int PIXEL_WIDTH           = optflow_pkg::PIXEL_WIDTH,
   parameter int FRAME_WIDTH           = optflow_pkg::FRAME_WIDTH,
   parameter int FRAME_HEIGHT          = optflow_pkg::FRAME_HEIGHT,
   parameter int NUM_DERIVATIVE_FRAMES = optflow_pkg::NUM_DERIVATIVE_FRAMES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pix_valid,
   input  logic                   pix_sof,
   input  logic [PIXEL_WIDTH-1:0] pix_in,
   output logic [PIXEL_WIDTH*NUM_DERIVATIVE_FRAMES-1:0] pixels_out,
   output logic                   out_en,
   output logic                   out_sof,
   output logic                   stack_ready
`ifdef FRAME_STACK_ERR_CNT_EN
   ,
   output logic [15:0]            err_count
`endif
);

   import optflow_pkg::*;

   localparam int N    = NUM_DERIVATIVE_FRAMES;
   localparam int NS   = N - 1;
   localparam int NPIX = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int PW   = PIXEL_WIDTH;
   localparam int AW   = idx_w(NPIX);
   localparam int CW   = idx_w(FRAME_WIDTH);
   localparam int RW   = idx_w(FRAME_HEIGHT);
   localparam int SW   = idx_w(NS);
   localparam int HW   = idx_w(N);

   feed_state_t     state;
   logic [CW-1:0]   col;
   logic [CW-1:0]   cur_col;
   logic [RW-1:0]   row;
   logic [RW-1:0]   cur_row;
   logic [SW-1:0]   wr_slot;
   logic [SW-1:0]   slot_q;
   logic [HW-1:0]   hist;
   logic [HW-1:0]   hist_nxt;
   logic [AW-1:0]   addr;
   logic            accept;
   logic            last;
   logic            full;
   logic            v_q;
   logic            sof_q;
   logic [PW-1:0]   live_q;
   logic [PW-1:0]   rd_data [NS];
   logic [PW*N-1:0] lanes;

   // A sof pixel always lands at address 0, even mid-frame.
   always_comb begin
      accept   = pix_valid && (pix_sof || state == ACTIVE);
      cur_col  = pix_sof ? '0 : col;
      cur_row  = pix_sof ? '0 : row;
      addr     = AW'(cur_row) * AW'(FRAME_WIDTH) + AW'(cur_col);
      last     = (cur_col == CW'(FRAME_WIDTH - 1)) &&
                 (cur_row == RW'(FRAME_HEIGHT - 1));
      full     = (hist == HW'(NS));
      hist_nxt = (accept && last && !full) ? hist + 1'b1 : hist;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         wr_slot     <= '0;
         hist        <= '0;
         stack_ready <= 1'b0;
      end else begin
         hist        <= hist_nxt;
         stack_ready <= (hist_nxt == HW'(NS));
         if (accept) begin
            if (last) begin
               state   <= IDLE;
               col     <= '0;
               row     <= '0;
               wr_slot <= (wr_slot == SW'(NS - 1)) ? '0 : wr_slot + 1'b1;
            end else begin
               state <= ACTIVE;
               if (cur_col == CW'(FRAME_WIDTH - 1)) begin
                  col <= '0;
                  row <= cur_row + 1'b1;
               end else begin
                  col <= cur_col + 1'b1;
                  row <= cur_row;
               end
            end
         end
      end
   end

   for (genvar s = 0; s < NS; s++) begin : g_slot
      frame_slot_ram #(
         .DATA_W (PW),
         .ADDR_W (AW),
         .DEPTH  (NPIX)
      ) u_ram (
         .clk     (clk),
         .wr_en   (accept && (wr_slot == SW'(s))),
         .wr_addr (addr),
         .wr_data (pix_in),
         .rd_addr (addr),
         .rd_data (rd_data[s])
      );
   end

   // Oldest lane reads the slot being overwritten; RAM gives old data.
   always_comb begin
      lanes         = '0;
      lanes[PW-1:0] = live_q;
      for (int k = 1; k < N; k++) begin
         lanes[k*PW +: PW] =
            rd_data[SW'((int'(slot_q) + NS * N - k) % NS)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q        <= 1'b0;
         sof_q      <= 1'b0;
         live_q     <= '0;
         slot_q     <= '0;
         out_en     <= 1'b0;
         out_sof    <= 1'b0;
         pixels_out <= '0;
      end else begin
         v_q    <= accept && full;
         sof_q  <= accept && full && pix_sof;
         live_q <= pix_in;
         slot_q <= wr_slot;
         out_en  <= v_q;
         out_sof <= sof_q;
         if (v_q) begin
            pixels_out <= lanes;
         end
      end
   end

`ifdef FRAME_STACK_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (pix_valid && pix_sof && state == ACTIVE &&
                   err_count != 16'hFFFF) begin
         err_count <= err_count + 1'b1;
      end
   end
`endif

endmodule
